// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: sums COUNT legal adder results per frame and hands the total downstream
// Ports: clk/rst_n (async active-low) | i_in_valid, o_in_ready, i_sum_in: sample input handshake
//        o_out_valid, i_out_ready, o_acc_out: frame total handshake | o_acc_sat: frame saturated
//        o_err_range: one-cycle pulse after an out-of-range sample is discarded
module adder_sum_accumulator #(
  parameter int SUM_W   = 5,
  parameter int ACC_W   = 8,
  parameter int COUNT   = 4,
  parameter int MAX_SUM = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [SUM_W-1:0] i_sum_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_acc_out,
  output logic             o_acc_sat,
  output logic             o_err_range
);
  localparam int CNT_W = $clog2(COUNT + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_sat, w_sat_nxt, r_err, w_err_nxt;
  logic [ACC_W:0]   w_sum;
  logic             w_legal;
  // one extra bit so overflow past 2^ACC_W-1 is visible as the carry
  assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(i_sum_in);
  assign w_legal = i_sum_in <= SUM_W'(MAX_SUM);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_sat_nxt   = r_sat;
    w_err_nxt   = 1'b0;
    if (r_state == HOLD) begin
      if (i_out_ready) begin
        w_state_nxt = ACCUM;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
        w_sat_nxt   = 1'b0;
      end
    end else if (i_in_valid) begin
      if (w_legal) begin
        w_acc_nxt   = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
        w_sat_nxt   = r_sat | w_sum[ACC_W];
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_state_nxt = (r_cnt == CNT_W'(COUNT - 1)) ? HOLD : ACCUM;
      end else begin
        w_err_nxt = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      r_sat   <= w_sat_nxt;
      r_err   <= w_err_nxt;
    end
  end
  assign o_in_ready  = r_state == ACCUM;
  assign o_out_valid = r_state == HOLD;
  assign o_acc_out   = r_acc;
  assign o_acc_sat   = r_sat;
  assign o_err_range = r_err;
endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb_adder_sum_accumulator: scoreboard bench for an 8-bit and a 6-bit accumulator driven in lockstep
module tb_adder_sum_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] sum_in = '0;
  logic       rdy8, vld8, sat8, err8, rdy6, vld6, sat6, err6;
  logic [7:0] acc8;
  logic [5:0] acc6;
  typedef struct {int t8; int s8; int t6; int s6;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int n_vec = 0, n_err = 0;
  int m_acc8, m_acc6, m_sat8, m_sat6, m_cnt, m_hold, m_err;
  logic prev_v;
  always #5 clk = ~clk;
  adder_sum_accumulator u8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy8), .i_sum_in(sum_in),
    .o_out_valid(vld8), .i_out_ready(out_ready), .o_acc_out(acc8), .o_acc_sat(sat8), .o_err_range(err8)
  );
  adder_sum_accumulator #(.ACC_W(6)) u6 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy6), .i_sum_in(sum_in),
    .o_out_valid(vld6), .i_out_ready(out_ready), .o_acc_out(acc6), .o_acc_sat(sat6), .o_err_range(err6)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    m_acc8 = 0; m_acc6 = 0; m_sat8 = 0; m_sat6 = 0; m_cnt = 0; m_hold = 0; m_err = 0;
    prev_v = 1'b0;
    sb.delete();
  endtask
  task automatic step(input logic v, input int s, input logic r);
    in_valid = v; sum_in = 5'(s); out_ready = r;
    m_err = 0;
    if (m_hold != 0) begin
      if (r) begin
        m_hold = 0; m_cnt = 0; m_acc8 = 0; m_acc6 = 0; m_sat8 = 0; m_sat6 = 0;
      end
    end else if (v) begin
      if (s > 30) m_err = 1;
      else begin
        m_acc8 += s;
        m_acc6 += s;
        if (m_acc8 > 255) begin m_acc8 = 255; m_sat8 = 1; end
        if (m_acc6 > 63) begin m_acc6 = 63; m_sat6 = 1; end
        m_cnt++;
        if (m_cnt == 4) begin
          m_hold = 1;
          sb.push_back('{m_acc8, m_sat8, m_acc6, m_sat6});
        end
      end
    end
    @(posedge clk);
    #1;
    check("in_ready8", rdy8, 32'(m_hold == 0));
    check("in_ready6", rdy6, 32'(m_hold == 0));
    check("out_valid8", vld8, 32'(m_hold));
    check("out_valid6", vld6, 32'(m_hold));
    check("err_range8", err8, 32'(m_err));
    check("err_range6", err6, 32'(m_err));
    check("acc8", acc8, 32'(m_acc8));
    check("acc6", acc6, 32'(m_acc6));
    check("sat8", sat8, 32'(m_sat8));
    check("sat6", sat6, 32'(m_sat6));
    if (vld8 && !prev_v) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        cur = sb.pop_front();
        check("frame_total8", acc8, 32'(cur.t8));
        check("frame_sat8", sat8, 32'(cur.s8));
        check("frame_total6", acc6, 32'(cur.t6));
        check("frame_sat6", sat6, 32'(cur.s6));
      end
    end
    prev_v = vld8;
  endtask
  task automatic frame(input int a, input int b, input int c, input int d, input logic r);
    step(1'b1, a, r); step(1'b1, b, r); step(1'b1, c, r); step(1'b1, d, r);
  endtask
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_acc8", acc8, 0);
    check("rst_acc6", acc6, 0);
    check("rst_valid", vld8, 0);
    check("rst_ready", rdy8, 1);
    check("rst_sat", sat6, 0);
    check("rst_err", err8, 0);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    model_clear();
    #1;
    check("reset_acc", acc8, 0);
    check("reset_valid", vld8, 0);
    check("reset_ready", rdy8, 1);
    check("reset_sat", sat8, 0);
    check("reset_err", err8, 0);
    #2 rst_n = 1'b1;
    frame(3, 30, 0, 15, 1'b1);
    step(1'b0, 0, 1'b1);
    frame(3, 30, 0, 15, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 7, 1'b0);
    step(1'b1, 7, 1'b1);
    frame(7, 7, 7, 7, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 10, 1'b0); step(1'b1, 31, 1'b0);
    frame(5, 7, 8, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    frame(30, 30, 30, 30, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 3, 1'b1); step(1'b0, 31, 1'b1); step(1'b1, 30, 1'b1); step(1'b0, 9, 1'b1);
    step(1'b1, 0, 1'b1); step(1'b0, 31, 1'b1); step(1'b1, 15, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b1, 12, 1'b1); step(1'b1, 9, 1'b1);
    reset_pulse();
    frame(1, 1, 1, 1, 1'b0);
    step(1'b0, 0, 1'b1);
    frame(30, 30, 30, 30, 1'b1);
    reset_pulse();
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream stage of the registered 4-bit adder; consumes its 5-bit Sum output, one result per valid/ready handshake.
- Accumulates COUNT legal Sum samples into one frame total.
- Presents the total to the next stage with a valid/ready handshake, saturation flag and range-error pulse.
- Back-pressures the upstream while a finished total waits to be taken.

Parameters:
- SUM_W, 5, width of incoming sum.
- ACC_W, 8, accumulator/output width; must be >= SUM_W.
- COUNT, 4, legal samples per frame; must be >= 1.
- MAX_SUM, 30, largest legal sample value (15+15).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sum_in is valid.
- in_ready  out  1  block accepts a sample this cycle.
- sum_in  in  SUM_W  adder result.
- out_valid  out  1  acc_out holds a completed frame total.
- out_ready  in  1  downstream accepts acc_out.
- acc_out  out  ACC_W  accumulator value; final total when out_valid=1.
- acc_sat  out  1  saturation occurred in the current frame.
- err_range  out  1  one-cycle pulse, out-of-range sample discarded.

Behaviour:
- Reset (async, rst_n=0):
  - State ACCUM, sample count=0.
  - acc_out=0, out_valid=0, acc_sat=0, err_range=0.
  - in_ready=1, since in_ready is combinational: in_ready = (state==ACCUM).
  - Reset mid-frame or mid-HOLD discards all partial and pending data.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept: in_valid && in_ready at posedge. in_valid while in_ready=0 is ignored.
- Legal sample (sum_in <= MAX_SUM), on accept:
  - acc_out <= acc_out + sum_in, computed at ACC_W+1 bits.
  - If the result exceeds 2^ACC_W-1: acc_out <= all ones, acc_sat <= 1. acc_sat is sticky for the frame.
  - count <= count+1.
- Illegal sample (sum_in > MAX_SUM), on accept:
  - Handshake completes, value discarded.
  - acc_out and count unchanged.
  - err_range=1 for exactly the following cycle.
- Frame completion: the accept that brings count to COUNT moves state to HOLD.
  - out_valid=1 the cycle after the last accept (latency 1).
  - acc_out is the full frame total.
- HOLD:
  - acc_out, acc_sat, out_valid held stable until out_ready=1.
  - On out_valid && out_ready at posedge: state ACCUM, count=0, acc_out=0, acc_sat=0, out_valid=0 next cycle.
  - The first new sample can be accepted the cycle after the handoff; there is one bubble cycle.
- Simultaneous events:
  - out_ready sampled while in ACCUM has no effect.
  - A handoff cycle never accepts input, because in_ready=0 in HOLD.
- err_range is independent of state and never asserted in HOLD.

Test Plan:
- Normal frame: samples 3, 30, 0, 15 accepted on consecutive cycles, out_ready=1 -> one cycle after the 4th accept, out_valid=1, acc_out=48, acc_sat=0. Next cycle out_valid=0, acc_out=0, in_ready=1.
- Back-pressure: complete frame 48, hold out_ready=0 for 5 cycles while in_valid=1 with sum_in=7 -> in_ready=0, acc_out stays 48, no sample accepted. Raise out_ready -> handoff, then the next frame starts from 0.
- Range error: samples 10, 31, 5, 7, 8 -> err_range pulses once, the cycle after 31 is accepted. Frame completes after 8 with acc_out=30.
- Saturation (ACC_W=6, COUNT=4): samples 30, 30, 30, 30 -> acc_out=63, acc_sat=1 at out_valid. acc_sat=0 after handoff.
- Gapped input: the normal-frame samples with in_valid high only every other cycle -> same total 48. Count advances only on handshakes.
- Async reset mid-frame: after samples 12 and 9, pulse rst_n low between clock edges -> acc_out=0, out_valid=0, in_ready=1 immediately. A following 4-sample frame of 1s gives 4.
